// File: rtl/baccarat_pkg.sv
// Shared card definitions for the dealer, the card7seg decoders and the game controller.
package baccarat_pkg;

   typedef logic [3:0] card_t;

   localparam card_t CARD_BLANK = 4'd0;
   localparam card_t CARD_ACE   = 4'd1;
   localparam card_t CARD_TEN   = 4'd10;
   localparam card_t CARD_JACK  = 4'd11;
   localparam card_t CARD_QUEEN = 4'd12;
   localparam card_t CARD_KING  = 4'd13;

   // Baccarat point value: ace..nine count face value, tens/faces/blank count zero.
   function automatic logic [3:0] card_value(input card_t c);
      if (c >= CARD_ACE && c < CARD_TEN) begin
         return c;
      end
      return 4'd0;
   endfunction

endpackage : baccarat_pkg

// File: rtl/hand_dealer_if.sv
// Request/response bundle between the game controller and the hand dealer.
interface hand_dealer_if #(
   parameter int NUM_SLOTS = 3
);
   import baccarat_pkg::*;

   logic                        deal;
   logic                        clear;
   card_t [NUM_SLOTS-1:0]       card_o;
   logic  [3:0]                 score_o;
   logic  [1:0]                 count_o;
   logic                        full_o;
   logic                        deal_ack;
   card_t                       rank_o;

   // Controller side: issues deal/clear, observes the hand.
   modport master (
      output deal, clear,
      input  card_o, score_o, count_o, full_o, deal_ack, rank_o
   );

   // Dealer side.
   modport slave (
      input  deal, clear,
      output card_o, score_o, count_o, full_o, deal_ack, rank_o
   );

endinterface : hand_dealer_if

// File: rtl/rank_counter.sv
// Free-running rank source: cycles 1..13 on every non-reset edge.
module rank_counter
   import baccarat_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   output card_t rank_o
);

   card_t rank_q;
   card_t rank_d;

   // Next rank with king wrapping back to ace; 0, 14 and 15 never appear.
   always_comb begin
      rank_d = rank_q + 4'd1;
      if (rank_q >= CARD_KING) begin
         rank_d = CARD_ACE;
      end
   end

   // Rank register.
   always_ff @(posedge clk) begin
      if (reset) begin
         rank_q <= CARD_ACE;
      end else begin
         rank_q <= rank_d;
      end
   end

   assign rank_o = rank_q;

endmodule : rank_counter

// File: rtl/hand_dealer.sv
// Deals ranks from the free-running counter into a hand of NUM_SLOTS slots
// and reports the baccarat score of the hand.
module hand_dealer
   import baccarat_pkg::*;
#(
   parameter int NUM_SLOTS = 3
)(
   input  logic          clk,
   input  logic          reset,
   hand_dealer_if.slave  bus
);

   card_t        rank;
   card_t        slot_card [NUM_SLOTS];
   logic [1:0]   count_q;
   logic [1:0]   count_d;
   logic         ack_q;
   logic         ack_d;
   logic         full;
   logic         accept;
   logic [4:0]   score_sum;
   logic [4:0]   score_mod;

   rank_counter u_rank_counter (
      .clk    (clk),
      .reset  (reset),
      .rank_o (rank)
   );

   assign full   = (count_q == 2'(NUM_SLOTS));
   // Clear wins over deal, and a full hand refuses further cards.
   assign accept = bus.deal & ~bus.clear & ~full;

   // Fill count and acknowledge pulse for the next cycle.
   always_comb begin
      count_d = count_q;
      ack_d   = 1'b0;
      if (bus.clear) begin
         count_d = 2'd0;
      end else if (accept) begin
         count_d = count_q + 2'd1;
         ack_d   = 1'b1;
      end
   end

   // Count and ack registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= 2'd0;
         ack_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ack_q   <= ack_d;
      end
   end

   // One register per slot; the slot indexed by the current count takes the rank.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         card_t slot_q;
         card_t slot_d;

         // Slot next-state: blank on clear, capture pre-edge rank when this slot is next.
         always_comb begin
            slot_d = slot_q;
            if (bus.clear) begin
               slot_d = CARD_BLANK;
            end else if (accept && (count_q == 2'(gi))) begin
               slot_d = rank;
            end
         end

         // Slot register.
         always_ff @(posedge clk) begin
            if (reset) begin
               slot_q <= CARD_BLANK;
            end else begin
               slot_q <= slot_d;
            end
         end

         assign slot_card[gi]  = slot_q;
         assign bus.card_o[gi] = slot_q;
      end
   endgenerate

   // Hand score straight from the registered slots so it tracks the cards same-cycle.
   always_comb begin
      score_sum = 5'd0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         score_sum = score_sum + 5'(card_value(slot_card[i]));
      end
      score_mod = score_sum % 5'd10;
   end

   assign bus.score_o  = score_mod[3:0];
   assign bus.count_o  = count_q;
   assign bus.full_o   = full;
   assign bus.deal_ack = ack_q;
   assign bus.rank_o   = rank;

endmodule : hand_dealer

// File: tb/tb_hand_dealer.sv
// Directed bench for hand_dealer with a reference model and a deal scoreboard.
module tb_hand_dealer;

   localparam int NS = 3;

   logic clk;
   logic reset;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_rank  = 1;
   int m_slot [NS];
   int m_count = 0;
   int m_ack   = 0;

   typedef struct { int slot; int rank; } sb_t;
   sb_t exp_q [$];

   hand_dealer_if #(.NUM_SLOTS(NS)) hif ();

   hand_dealer #(.NUM_SLOTS(NS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (hif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Apply current inputs on one edge, advance the model, compare every output.
   task automatic tick();
      int score;
      bit acc;
      if (reset) begin
         m_rank = 1; m_count = 0; m_ack = 0;
         for (int i = 0; i < NS; i++) m_slot[i] = 0;
      end else begin
         acc = hif.deal && !hif.clear && (m_count < NS);
         if (hif.clear) begin
            m_count = 0;
            for (int i = 0; i < NS; i++) m_slot[i] = 0;
         end else if (acc) begin
            m_slot[m_count] = m_rank;
            exp_q.push_back('{slot: m_count, rank: m_rank});
            m_count++;
         end
         m_ack  = acc ? 1 : 0;
         m_rank = (m_rank == 13) ? 1 : m_rank + 1;
      end
      @(posedge clk);
      #1;
      score = 0;
      for (int i = 0; i < NS; i++) begin
         if (m_slot[i] >= 1 && m_slot[i] <= 9) score += m_slot[i];
         chk($sformatf("card%0d", i), 32'(hif.card_o[i]), m_slot[i]);
      end
      chk("count", 32'(hif.count_o), m_count);
      chk("full", 32'(hif.full_o), (m_count == NS) ? 1 : 0);
      chk("ack", 32'(hif.deal_ack), m_ack);
      chk("score", 32'(hif.score_o), score % 10);
      chk("rank", 32'(hif.rank_o), m_rank);
      if (hif.deal_ack === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_ack", 32'd1, 32'd0);
         end else begin
            sb_t e;
            e = exp_q.pop_front();
            chk("sb_card", 32'(hif.card_o[e.slot]), e.rank);
         end
      end
      $display("t=%0t deal=%0b clear=%0b reset=%0b rank=%0d cards=%0d,%0d,%0d cnt=%0d score=%0d ack=%0b",
               $time, hif.deal, hif.clear, reset, hif.rank_o, hif.card_o[0], hif.card_o[1],
               hif.card_o[2], hif.count_o, hif.score_o, hif.deal_ack);
   endtask

   // Idle until the model rank equals r (bounded by one full rank cycle).
   task automatic wait_rank(input int r);
      int n = 0;
      while (m_rank != r && n < 14) begin
         tick();
         n++;
      end
      chk("wait_rank", m_rank, r);
   endtask

   initial begin
      int prev_rank;
      reset     = 1'b1;
      hif.deal  = 1'b0;
      hif.clear = 1'b0;
      for (int i = 0; i < NS; i++) m_slot[i] = 0;

      // 1. reset
      tick();
      chk("rst_rank", 32'(hif.rank_o), 1);
      chk("rst_score", 32'(hif.score_o), 0);
      chk("rst_count", 32'(hif.count_o), 0);
      chk("rst_full", 32'(hif.full_o), 0);
      chk("rst_ack", 32'(hif.deal_ack), 0);
      reset = 1'b0;

      // 2. wrap
      for (int i = 0; i < 12; i++) tick();
      chk("wrap_13", 32'(hif.rank_o), 13);
      tick();
      chk("wrap_1", 32'(hif.rank_o), 1);

      // 3. single deal at rank 7
      wait_rank(7);
      hif.deal = 1'b1;
      tick();
      hif.deal = 1'b0;
      chk("d7_card0", 32'(hif.card_o[0]), 7);
      chk("d7_score", 32'(hif.score_o), 7);
      chk("d7_count", 32'(hif.count_o), 1);
      chk("d7_ack", 32'(hif.deal_ack), 1);
      tick();
      chk("d7_ack_drop", 32'(hif.deal_ack), 0);

      // 4. fresh hand: 9, 8, 12, then a refused fourth deal
      hif.clear = 1'b1;
      tick();
      hif.clear = 1'b0;
      wait_rank(9);
      hif.deal = 1'b1; tick(); hif.deal = 1'b0;
      chk("h_score1", 32'(hif.score_o), 9);
      wait_rank(8);
      hif.deal = 1'b1; tick(); hif.deal = 1'b0;
      chk("h_score2", 32'(hif.score_o), 7);
      wait_rank(12);
      hif.deal = 1'b1; tick(); hif.deal = 1'b0;
      chk("h_score3", 32'(hif.score_o), 7);
      chk("h_full", 32'(hif.full_o), 1);
      hif.deal = 1'b1; tick(); hif.deal = 1'b0;
      chk("h_4th_ack", 32'(hif.deal_ack), 0);
      chk("h_4th_card2", 32'(hif.card_o[2]), 12);
      chk("h_4th_count", 32'(hif.count_o), 3);

      // 5. clear and deal on the same edge mid-hand
      hif.clear = 1'b1; tick(); hif.clear = 1'b0;
      hif.deal = 1'b1; tick(); hif.deal = 1'b0;
      prev_rank = 32'(hif.rank_o);
      hif.deal = 1'b1; hif.clear = 1'b1;
      tick();
      hif.deal = 1'b0; hif.clear = 1'b0;
      chk("cd_card0", 32'(hif.card_o[0]), 0);
      chk("cd_count", 32'(hif.count_o), 0);
      chk("cd_score", 32'(hif.score_o), 0);
      chk("cd_ack", 32'(hif.deal_ack), 0);
      chk("cd_rank", 32'(hif.rank_o), (prev_rank == 13) ? 1 : prev_rank + 1);

      // 6. held deal from rank 12 wraps through king to ace, then reset
      wait_rank(12);
      hif.deal = 1'b1;
      tick(); tick(); tick();
      hif.deal = 1'b0;
      chk("hold_s0", 32'(hif.card_o[0]), 12);
      chk("hold_s1", 32'(hif.card_o[1]), 13);
      chk("hold_s2", 32'(hif.card_o[2]), 1);
      chk("hold_score", 32'(hif.score_o), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst2_rank", 32'(hif.rank_o), 1);
      chk("rst2_card2", 32'(hif.card_o[2]), 0);
      chk("rst2_count", 32'(hif.count_o), 0);
      chk("rst2_score", 32'(hif.score_o), 0);
      chk("rst2_full", 32'(hif.full_o), 0);
      chk("sb_drain", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_hand_dealer
